// File: rtl/fsm_pattern_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// The detector's reset configuration defaults to the legacy three-ones detector.
package fsm_pattern_pkg;

   localparam int unsigned DEF_LEN     = 32'd3;
   localparam logic [31:0] DEF_PATTERN = 32'b111;
   localparam logic        DEF_OVERLAP = 1'b1;

   function automatic int unsigned len_width(input int unsigned max_len);
      return $clog2(max_len + 32'd1);
   endfunction

   // A zero length degenerates to a single-bit compare; oversize lengths are capped.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      if (len == 32'd0) begin
         return 32'd1;
      end else if (len > max_len) begin
         return max_len;
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/fsm_pattern_detector_param_if.sv
// Configuration, serial-stream and result signals of the pattern detector.
// The cfg_mask signal exists only when PATTERN_MASK_EN is defined.
interface fsm_pattern_detector_param_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   parameter int LEN_W   = fsm_pattern_pkg::len_width(MAX_LEN)
);
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
`ifdef PATTERN_MASK_EN
   logic [MAX_LEN-1:0] cfg_mask;
`endif
   logic               in_valid;
   logic               in_i;
   logic               detect;
   logic               detect_q;
   logic [CNT_W-1:0]   match_count;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap,
`ifdef PATTERN_MASK_EN
      output cfg_mask,
`endif
      output in_valid, in_i,
      input  detect, detect_q, match_count
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap,
`ifdef PATTERN_MASK_EN
      input  cfg_mask,
`endif
      input  in_valid, in_i,
      output detect, detect_q, match_count
   );
endinterface

// File: rtl/fsm_pattern_detector_param_cmp.sv
// Combinational compare of the low len bits of a window against a pattern.
// Bits with mask=0 never cause a mismatch.
module pattern_window_cmp #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic [MAX_LEN-1:0] window_i,
   input  logic [MAX_LEN-1:0] pattern_i,
   input  logic [MAX_LEN-1:0] mask_i,
   input  logic [LEN_W-1:0]   len_i,
   output logic               match_o
);
   logic [MAX_LEN-1:0] miss_s;

   // Per-bit mismatch, restricted to the active length and mask.
   always_comb begin
      miss_s = {MAX_LEN{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
         miss_s[i] = (LEN_W'(i) < len_i) & mask_i[i] & (window_i[i] ^ pattern_i[i]);
      end
   end

   assign match_o = ~(|miss_s);
endmodule

// File: rtl/fsm_pattern_detector_param.sv
// Runtime-configurable serial pattern detector with Mealy detect, registered copy
// and saturating match counter. Define PATTERN_MASK_EN for don't-care mask bits.
module fsm_pattern_detector_param
   import fsm_pattern_pkg::*;
#(
   parameter int                      MAX_LEN     = 8,
   parameter int unsigned             RST_LEN     = DEF_LEN,
   parameter logic [MAX_LEN-1:0]      RST_PATTERN = MAX_LEN'(DEF_PATTERN),
   parameter logic                    RST_OVERLAP = DEF_OVERLAP,
   parameter int                      CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   fsm_pattern_detector_param_if.slave   bus
);
   localparam int LEN_W = len_width(MAX_LEN);
   localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, MAX_LEN));
   localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN - 1);

   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic [MAX_LEN-2:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               detect_dly_q;
   logic [MAX_LEN-1:0] mask_s;
   logic [MAX_LEN-1:0] window_s;
   logic [LEN_W-1:0]   cfg_len_clamped_s;
   logic               cmp_match_s;
   logic               fill_ok_s;
   logic               detect_s;

`ifdef PATTERN_MASK_EN
   logic [MAX_LEN-1:0] mask_q, mask_d;
   assign mask_s = mask_q;
`else
   assign mask_s = {MAX_LEN{1'b1}};
`endif

   assign window_s          = {hist_q, bus.in_i};
   assign cfg_len_clamped_s = LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
   // Enough bits seen once fill >= len-1; the live input supplies the last bit.
   assign fill_ok_s = ({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q};

   pattern_window_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_cmp (
      .window_i  (window_s),
      .pattern_i (pattern_q),
      .mask_i    (mask_s),
      .len_i     (len_q),
      .match_o   (cmp_match_s)
   );

   assign detect_s = bus.in_valid & ~bus.cfg_we & cmp_match_s & fill_ok_s;

   // Next-state: configuration load, history shift, fill tracking, match counter.
   always_comb begin
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
`ifdef PATTERN_MASK_EN
      mask_d    = mask_q;
`endif
      if (bus.cfg_we) begin
         pattern_d = bus.cfg_pattern;
         len_d     = cfg_len_clamped_s;
         overlap_d = bus.cfg_overlap;
`ifdef PATTERN_MASK_EN
         mask_d    = bus.cfg_mask;
`endif
         hist_d    = {(MAX_LEN-1){1'b0}};
         fill_d    = {LEN_W{1'b0}};
      end else if (bus.in_valid) begin
         hist_d = window_s[MAX_LEN-2:0];
         // Non-overlapping mode restarts the search from scratch after a match.
         if (detect_s && !overlap_q) begin
            fill_d = {LEN_W{1'b0}};
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + LEN_W'(1);
         end else begin
            fill_d = fill_q;
         end
      end else begin
         hist_d = hist_q;
         fill_d = fill_q;
      end

      if (detect_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State register with synchronous reset to the legacy configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_q    <= RST_PATTERN;
         len_q        <= RST_LEN_C;
         overlap_q    <= RST_OVERLAP;
         hist_q       <= {(MAX_LEN-1){1'b0}};
         fill_q       <= {LEN_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         detect_dly_q <= 1'b0;
`ifdef PATTERN_MASK_EN
         mask_q       <= {MAX_LEN{1'b1}};
`endif
      end else begin
         pattern_q    <= pattern_d;
         len_q        <= len_d;
         overlap_q    <= overlap_d;
         hist_q       <= hist_d;
         fill_q       <= fill_d;
         cnt_q        <= cnt_d;
         detect_dly_q <= detect_s;
`ifdef PATTERN_MASK_EN
         mask_q       <= mask_d;
`endif
      end
   end

   assign bus.detect      = detect_s;
   assign bus.detect_q    = detect_dly_q;
   assign bus.match_count = cnt_q;
endmodule
